// File: rtl/sram_mem_controller.sv
// Sequences 32-bit MEM-stage loads/stores onto a 16-bit asynchronous SRAM as two
// halfword phases (low, then high) with programmable wait states per phase.
module sram_mem_controller #(
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned SRAM_AW     = 18,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n,
    output logic               sram_oe_n
);

    localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 is_wr_q, is_wr_d;
    logic [SRAM_AW-2:0]   hw_q, hw_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [31:0]          read_data_q, read_data_d;
    logic [SRAM_AW-1:0]   sram_addr_q, sram_addr_d;
    logic [15:0]          dq_out_q, dq_out_d;
    logic                 dq_oe_q, dq_oe_d;
    logic                 we_n_q, we_n_d;
    logic                 oe_n_q, oe_n_d;

    logic                 req;
    logic [31:0]          off;
    logic                 unused_off_bits;

    assign req             = rd_en | wr_en;
    assign off             = address - 32'(BASE_ADDR);
    assign unused_off_bits = ^{off[31:SRAM_AW+1], off[1:0]};

    // ready drops combinationally in IDLE so the pipeline freezes in the request cycle
    assign ready       = (state_q == IDLE) ? ~req : (state_q == DONE);
    assign read_data   = read_data_q;
    assign sram_addr   = sram_addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_we_n   = we_n_q;
    assign sram_oe_n   = oe_n_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_wr_d     = is_wr_q;
        hw_d        = hw_q;
        wdata_d     = wdata_q;
        read_data_d = read_data_q;
        sram_addr_d = '0;
        dq_out_d    = '0;
        dq_oe_d     = 1'b0;
        we_n_d      = 1'b1;
        oe_n_d      = 1'b1;

        case (state_q)
            IDLE: begin
                if (req) begin
                    is_wr_d = wr_en;
                    hw_d    = off[SRAM_AW:2];
                    wdata_d = write_data;
                    cnt_d   = '0;
                    state_d = LO;
                end
            end
            LO: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = HI;
                    if (!is_wr_q) read_data_d[15:0] = sram_dq_in;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HI: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    if (!is_wr_q) read_data_d[31:16] = sram_dq_in;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // SRAM strobes are registered from the next state so they align with LO/HI
        if (state_d == LO || state_d == HI) begin
            sram_addr_d = {hw_d, state_d == HI};
            if (is_wr_d) begin
                we_n_d   = 1'b0;
                dq_oe_d  = 1'b1;
                dq_out_d = (state_d == HI) ? wdata_d[31:16] : wdata_d[15:0];
            end else begin
                oe_n_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            is_wr_q     <= 1'b0;
            hw_q        <= '0;
            wdata_q     <= '0;
            read_data_q <= '0;
            sram_addr_q <= '0;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_wr_q     <= is_wr_d;
            hw_q        <= hw_d;
            wdata_q     <= wdata_d;
            read_data_q <= read_data_d;
            sram_addr_q <= sram_addr_d;
            dq_out_q    <= dq_out_d;
            dq_oe_q     <= dq_oe_d;
            we_n_q      <= we_n_d;
            oe_n_q      <= oe_n_d;
        end
    end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Directed bench for sram_mem_controller: table of word accesses against a small
// behavioural SRAM, plus reset and reset-during-read sequences.
module tb_sram_mem_controller;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, rd_en;
    logic [31:0] address, write_data, read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_we_n, sram_oe_n;

    sram_mem_controller #(.BASE_ADDR(1024), .SRAM_AW(18), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
        .write_data(write_data), .read_data(read_data), .ready(ready),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
        .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:63];
    always @(posedge clk) if (!sram_we_n) mem[sram_addr[5:0]] <= sram_dq_out;
    assign sram_dq_in = !sram_oe_n ? mem[sram_addr[5:0]] : 16'hBAD0;

    int n_checks = 0;
    int n_fail   = 0;
    int overlap  = 0;

    always @(negedge clk) if (!sram_we_n && !sram_oe_n) overlap++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          hw;
        logic [15:0] exp_lo;
        logic [15:0] exp_hi;
    } vec_t;

    vec_t vecs [9];

    task automatic run_access(input int idx, input vec_t v);
        int low, we_c, oe_c;
        low = 0; we_c = 0; oe_c = 0;
        @(negedge clk);
        wr_en = v.wr; rd_en = v.rd; address = v.addr; write_data = v.wdata;
        #1;
        while (!ready && low < 50) begin
            low++;
            if (!sram_we_n) we_c++;
            if (!sram_oe_n) oe_c++;
            @(negedge clk);
            // latched values must be used; scramble the bus after the request cycle
            address = $urandom; write_data = $urandom;
            #1;
        end
        check("ready_low_cycles", 32'(low), 32'(2 * W + 1));
        check("we_low_cycles", 32'(we_c), v.wr ? 32'(2 * W) : 32'd0);
        check("oe_low_cycles", 32'(oe_c), (!v.wr && v.rd) ? 32'(2 * W) : 32'd0);
        check("read_data", read_data, v.exp_rdata);
        check("mem_lo", {16'd0, mem[v.hw]}, {16'd0, v.exp_lo});
        check("mem_hi", {16'd0, mem[v.hw + 1]}, {16'd0, v.exp_hi});
        $display("vec %0d: wr=%0b rd=%0b addr=%0d ready_low=%0d we=%0d oe=%0d rdata=%h",
                 idx, v.wr, v.rd, v.addr, low, we_c, oe_c, read_data);
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
        //          wr    rd    addr  wdata          exp_rdata      hw  lo        hi
        vecs[0] = '{1'b1, 1'b0, 1024, 32'h0000_2000, 32'h0000_0000, 0, 16'h2000, 16'h0000};
        vecs[1] = '{1'b0, 1'b1, 1024, 32'h0,         32'h0000_2000, 0, 16'h2000, 16'h0000};
        vecs[2] = '{1'b1, 1'b0, 1028, 32'hC000_0000, 32'h0000_2000, 2, 16'h0000, 16'hC000};
        vecs[3] = '{1'b0, 1'b1, 1028, 32'h0,         32'hC000_0000, 2, 16'h0000, 16'hC000};
        vecs[4] = '{1'b1, 1'b1, 1030, 32'h1234_5678, 32'hC000_0000, 2, 16'h5678, 16'h1234};
        vecs[5] = '{1'b0, 1'b1, 1028, 32'h0,         32'h1234_5678, 2, 16'h5678, 16'h1234};
        vecs[6] = '{1'b1, 1'b0, 1040, 32'hDEAD_BEEF, 32'h1234_5678, 8, 16'hBEEF, 16'hDEAD};
        vecs[7] = '{1'b0, 1'b1, 1040, 32'h0,         32'hDEAD_BEEF, 8, 16'hBEEF, 16'hDEAD};
        vecs[8] = '{1'b0, 1'b1, 1024, 32'h0,         32'h0000_2000, 0, 16'h2000, 16'h0000};

        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_ready", {31'd0, ready}, 32'd1);
        check("reset_we_n", {31'd0, sram_we_n}, 32'd1);
        check("reset_oe_n", {31'd0, sram_oe_n}, 32'd1);
        check("reset_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
        check("reset_read_data", read_data, 32'd0);
        check("reset_sram_addr", {14'd0, sram_addr}, 32'd0);
        $display("reset: ready=%0b we_n=%0b oe_n=%0b rdata=%h", ready, sram_we_n, sram_oe_n, read_data);

        for (int i = 0; i < 9; i++) run_access(i, vecs[i]);

        // read_data holds after the request goes away
        repeat (3) @(negedge clk);
        check("hold_read_data", read_data, 32'h0000_2000);
        check("idle_ready", {31'd0, ready}, 32'd1);
        $display("hold: rdata=%h ready=%0b", read_data, ready);

        // reset asserted in the first HI cycle of a read of 1028
        @(negedge clk);
        rd_en = 1'b1; address = 1028;
        repeat (W + 1) @(negedge clk);
        check("mid_read_oe_active", {31'd0, sram_oe_n}, 32'd0);
        check("mid_read_hi_addr", {14'd0, sram_addr}, 32'd3);
        rst = 1'b1;
        @(negedge clk);
        check("abort_read_data", read_data, 32'd0);
        check("abort_ready_req", {31'd0, ready}, 32'd0);
        check("abort_oe_n", {31'd0, sram_oe_n}, 32'd1);
        check("abort_we_n", {31'd0, sram_we_n}, 32'd1);
        rd_en = 1'b0;
        #1;
        check("abort_ready_noreq", {31'd0, ready}, 32'd1);
        $display("abort: rdata=%h ready=%0b oe_n=%0b", read_data, ready, sram_oe_n);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("strobe_overlap", 32'(overlap), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
